// File: rtl/hazard_control.sv
// Pipeline sequencer for the 5-stage core: tracks EX/MEM/WB destinations and
// produces stall, bubble, flush, enable and EX forwarding controls.
module hazard_control #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs_addr,
  input  logic [4:0]       rt_addr,
  input  logic             uses_rs,
  input  logic             uses_rt,
  input  logic             is_branch,
  input  logic             jump,
  input  logic             id_rd_en,
  input  logic [4:0]       id_rd_addr,
  input  logic             id_load,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pipe_en,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic {ST_RUN, ST_FREEZE} state_t;

  state_t     state_q, state_d;

  logic       ex_rd_en_q, ex_load_q;
  logic [4:0] ex_rd_q, ex_rs_q, ex_rt_q;
  logic       mem_rd_en_q, mem_load_q;
  logic [4:0] mem_rd_q;
  logic       wb_rd_en_q;
  logic [4:0] wb_rd_q;

  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic [4:0] id_rs_src, id_rt_src;
  logic       ex_hit, mem_hit;
  logic       load_use, br_ex, br_load, br_mem, stall;

  function automatic logic hit(input logic en, input logic [4:0] rd, input logic [4:0] src);
    return en && (rd != '0) && (rd == src);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic m_en, input logic [4:0] m_rd,
                                         input logic m_load,
                                         input logic w_en, input logic [4:0] w_rd);
    if (hit(m_en, m_rd, src) && !m_load) return 2'b01;
    if (hit(w_en, w_rd, src))            return 2'b10;
    return 2'b00;
  endfunction

  // Unused sources are zeroed so they can never match (r0 never matches).
  assign id_rs_src = uses_rs ? rs_addr : '0;
  assign id_rt_src = uses_rt ? rt_addr : '0;

  assign ex_hit  = hit(ex_rd_en_q, ex_rd_q, id_rs_src) || hit(ex_rd_en_q, ex_rd_q, id_rt_src);
  assign mem_hit = hit(mem_rd_en_q, mem_rd_q, id_rs_src) || hit(mem_rd_en_q, mem_rd_q, id_rt_src);

  assign load_use = ex_load_q && ex_hit;
  assign br_ex    = is_branch && ex_hit && !ex_load_q;
  assign br_load  = is_branch && ex_hit && ex_load_q;
  assign br_mem   = is_branch && mem_hit && mem_load_q;
  assign stall    = load_use || br_ex || br_load || br_mem;

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_en      = 1'b1;
    fwd_a_sel    = 2'b00;
    fwd_b_sel    = 2'b00;
    if (rst) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else begin
      fwd_a_sel = fwd_sel(ex_rs_q, mem_rd_en_q, mem_rd_q, mem_load_q, wb_rd_en_q, wb_rd_q);
      fwd_b_sel = fwd_sel(ex_rt_q, mem_rd_en_q, mem_rd_q, mem_load_q, wb_rd_en_q, wb_rd_q);
      if (mem_busy) begin
        pc_en    = 1'b0;
        if_id_en = 1'b0;
        pipe_en  = 1'b0;
      end else if (stall) begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_bubble = 1'b1;
      end else begin
        if_id_flush = jump;
      end
    end
  end

  always_comb begin
    state_d       = mem_busy ? ST_FREEZE : ST_RUN;
    stall_count_d = stall_count_q;
    if (!pc_en && (stall_count_q != '1))
      stall_count_d = stall_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      stall_count_q <= '0;
      ex_rd_en_q    <= 1'b0;
      ex_load_q     <= 1'b0;
      ex_rd_q       <= '0;
      ex_rs_q       <= '0;
      ex_rt_q       <= '0;
      mem_rd_en_q   <= 1'b0;
      mem_load_q    <= 1'b0;
      mem_rd_q      <= '0;
      wb_rd_en_q    <= 1'b0;
      wb_rd_q       <= '0;
    end else begin
      state_q       <= state_d;
      stall_count_q <= stall_count_d;
      if (pipe_en) begin
        ex_rd_en_q  <= id_rd_en && !id_ex_bubble;
        ex_load_q   <= id_load && !id_ex_bubble;
        ex_rd_q     <= id_rd_addr;
        ex_rs_q     <= id_rs_src;
        ex_rt_q     <= id_rt_src;
        mem_rd_en_q <= ex_rd_en_q;
        mem_load_q  <= ex_load_q;
        mem_rd_q    <= ex_rd_q;
        wb_rd_en_q  <= mem_rd_en_q;
        wb_rd_q     <= mem_rd_q;
      end
    end
  end

  assign stall_count = stall_count_q;

  // FREEZE is only ever entered from a busy data memory on the previous cycle.
  a_freeze_src: assert property (@(posedge clk) disable iff (rst)
    (state_q == ST_FREEZE) |-> $past(mem_busy));

endmodule

// File: doc/hazard_control.md
Name: hazard_control

Overview:
Central pipeline sequencer for the 5-stage core (IF, ID, EX, MEM, WB).
- Keeps a shadow copy of the destination and source register fields for the EX, MEM and WB stages.
- From that copy it generates stall, bubble, flush and enable strobes for the pipeline registers, and EX-stage forwarding selects.
- Branch and jump resolution happens in ID, so the block also sequences operand-readiness stalls for branches.
- A freeze FSM holds the whole pipeline while data memory is busy.

Parameters:
CNT_W, 16, width of the saturating stall-cycle performance counter.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
rs_addr  in  5  ID-stage rs field
rt_addr  in  5  ID-stage rt field
uses_rs  in  1  ID instruction reads rs
uses_rt  in  1  ID instruction reads rt
is_branch  in  1  ID instruction compares rs/rt in ID
jump  in  1  ID resolved a taken branch or jump this cycle
id_rd_en  in  1  ID instruction writes a register
id_rd_addr  in  5  ID destination register
id_load  in  1  ID instruction is a load
mem_busy  in  1  data memory not ready; MEM stage cannot complete
pc_en  out  1  PC update enable
if_id_en  out  1  IF/ID register enable
if_id_flush  out  1  load a NOP into IF/ID
id_ex_bubble  out  1  load a NOP (rd_en=0, mem_en=0) into ID/EX
pipe_en  out  1  enable for ID/EX, EX/MEM and MEM/WB registers
fwd_a_sel  out  2  EX operand A source: 00 regfile, 01 EX/MEM, 10 MEM/WB
fwd_b_sel  out  2  EX operand B source, same encoding
stall_count  out  CNT_W  saturating count of cycles with pc_en=0 (reset excluded)

Behaviour:
Reset:
- While rst is high: shadow EX/MEM/WB entries cleared (rd_en=0, load=0, addresses 0), FSM=RUN, stall_count=0.
- Outputs during reset: pc_en=0, if_id_en=0, if_id_flush=1, id_ex_bubble=1, pipe_en=1, fwd selects 00.
- First cycle after reset deassertion: pc_en=1.

Shadow pipeline:
- Updated on each clk when pipe_en=1.
- EX entry <= ID fields (rd_en, rd_addr, load, rs_addr if uses_rs, rt_addr if uses_rt). If id_ex_bubble=1, the EX entry instead gets rd_en=0 and load=0.
- MEM entry <= EX entry; WB entry <= MEM entry.
- Any entry with rd_addr=0 never matches.

Hazards (combinational on ID fields vs. shadow; match = rd_en and rd_addr≠0 and address equal to a used source):
- LOAD_USE: EX entry is a load and matches rs or rt -> 1-cycle stall.
- BR_EX: is_branch and EX entry matches, not a load -> 1-cycle stall.
- BR_LOAD: is_branch and EX entry is a load and matches -> stall. It re-evaluates as BR_MEM next cycle, giving 2 cycles total.
- BR_MEM: is_branch and MEM entry is a load and matches -> 1-cycle stall.
- stall = any of the above.
- Effect of stall: pc_en=0, if_id_en=0, id_ex_bubble=1, pipe_en=1.

FSM states:
- RUN: normal operation.
- FREEZE: entered while mem_busy=1.
- Transitions: RUN->FREEZE when mem_busy=1; FREEZE->RUN on the first cycle mem_busy=0. The freeze condition is mem_busy itself (Mealy); the state is used only for the counter and debug.
- Outputs while mem_busy=1: pc_en=0, if_id_en=0, pipe_en=0, id_ex_bubble=0, if_id_flush=0. The shadow is frozen and forwarding selects hold their current combinational value.

Priority: mem_busy > stall > jump.
- if_id_flush = jump & ~stall & ~mem_busy.
- A jump asserted during a stall is ignored. ID re-evaluates it next cycle with valid operands.
- Flush with pc_en=1 and if_id_en=1 squashes the fall-through fetch: 1-cycle penalty.

Forwarding (EX operand A uses the EX entry's rs; B uses its rt):
- Select 01 if the MEM entry matches and is not a load.
- Else select 10 if the WB entry matches.
- Else 00.
- MEM beats WB when both match. A load in MEM never forwards; LOAD_USE guarantees it is not needed.

stall_count: increments by 1 on each non-reset cycle with pc_en=0, saturates at 2^CNT_W-1, no wrap.

Reset mid-freeze or mid-stall: rst wins in the same cycle; all state is cleared.

Test Plan:
- Back-to-back ALU (add r3 in EX/MEM, sub reads r3 in EX) -> fwd_a_sel=01; with one instruction between -> 10; r0 as destination -> 00.
- lw r5 followed by add using rt=r5 -> exactly one cycle of pc_en=0, id_ex_bubble=1; next cycle fwd_b_sel=10; stall_count=1.
- lw r7 followed by beq on r7 -> two stall cycles. A jump asserted during those cycles gives no flush; jump asserted on the third cycle -> if_id_flush=1.
- mem_busy high for 3 cycles during a load-use stall -> pc_en=0 and pipe_en=0 for 3 cycles, shadow unchanged, then the 1-cycle stall completes; stall_count=4.
- Back-to-back writers of r9 (MEM and WB entries both match) -> fwd_a_sel=01.
- rst asserted during FREEZE -> next cycle shadow cleared and stall_count=0; after release pc_en=1. Saturation check with CNT_W=2: 5 stall cycles -> stall_count=3.
